// File: rtl/key_expansion_ctrl_192.sv
// AES-192 key schedule sequencer: captures the key and writes w[0..51] into key memory via the word datapath.
// Latency: start to done is 53 cycles; one word is written per cycle, gap-free. Optional KEYEXP_RK_NOTIFY_EN.
// Backpressure: none. The memory must accept one write per cycle, and start is ignored outside IDLE.
module key_expansion_ctrl_192 #(
    parameter int NWORDS = 52,
    parameter int NK     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [191:0] key_in,
    output logic [5:0]   wg_i,
    output logic [31:0]  wg_prev_word,
    output logic [31:0]  wg_prev_period,
    input  logic [31:0]  wg_current_word,
    output logic         wr_en,
    output logic [5:0]   wr_addr,
    output logic [31:0]  wr_data,
    output logic         busy,
`ifdef KEYEXP_RK_NOTIFY_EN
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
`endif
    output logic         done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [5:0]        cnt;
    logic [5:0][31:0]  win;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   if (cnt == 6'(NK - 1)) state_nxt = S_EXPAND;
            S_EXPAND: if (cnt == 6'(NWORDS - 1)) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Window is win[0]=w[i-6] ... win[5]=w[i-1] while expanding.
    assign wg_i           = (state == S_EXPAND) ? cnt : 6'd0;
    assign wg_prev_word   = win[5];
    assign wg_prev_period = win[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            win     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        cnt <= '0;
                        for (int k = 0; k < NK; k++)
                            win[k] <= key_in[191 - 32*k -: 32];
                    end
                end
                S_LOAD: begin
                    wr_en   <= 1'b1;
                    wr_addr <= cnt;
                    wr_data <= win[cnt[2:0]];
                    busy    <= 1'b1;
                    cnt     <= cnt + 6'd1;
                end
                S_EXPAND: begin
                    wr_en   <= 1'b1;
                    wr_addr <= cnt;
                    wr_data <= wg_current_word;
                    busy    <= 1'b1;
                    for (int k = 0; k < NK - 1; k++)
                        win[k] <= win[k+1];
                    win[NK-1] <= wg_current_word;
                    if (cnt != 6'(NWORDS - 1))
                        cnt <= cnt + 6'd1;
                end
                S_DONE: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEYEXP_RK_NOTIFY_EN
    // Round key r is complete when word 4r+3 is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_idx   <= '0;
        end else begin
            rk_valid <= ((state == S_LOAD) || (state == S_EXPAND)) && (cnt[1:0] == 2'b11);
            rk_idx   <= cnt[5:2];
        end
    end
`endif

endmodule

// File: tb/tb_key_expansion_ctrl_192.sv
// Bench for key_expansion_ctrl_192: it models the word datapath and checks the write stream against a reference key schedule.
module tb_key_expansion_ctrl_192;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [191:0] key_in;
    logic [5:0]   wg_i;
    logic [31:0]  wg_prev_word, wg_prev_period, wg_current_word;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         busy, done;
`ifdef KEYEXP_RK_NOTIFY_EN
    logic         rk_valid;
    logic [3:0]   rk_idx;
`endif

    key_expansion_ctrl_192 dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .wg_i(wg_i), .wg_prev_word(wg_prev_word), .wg_prev_period(wg_prev_period),
        .wg_current_word(wg_current_word),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
`ifdef KEYEXP_RK_NOTIFY_EN
        .rk_valid(rk_valid), .rk_idx(rk_idx),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: inverse in GF(2^8) (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] r;
        logic [7:0] s;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        end
        s = inv ^ 8'h63;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s;
    endfunction

    function automatic logic [31:0] next_word(input int i, input logic [31:0] prev, input logic [31:0] period);
        logic [31:0] t = prev;
        logic [7:0]  rc = 8'h01;
        if (i % 6 == 0) begin
            t = {prev[23:0], prev[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            for (int k = 1; k < i / 6; k++) rc = gmul(rc, 8'h02);
            t = t ^ {rc, 24'h0};
        end
        return period ^ t;
    endfunction

    // Stand-in for current_word_gen_192.
    always_comb wg_current_word = next_word(int'(wg_i), wg_prev_word, wg_prev_period);

    logic [31:0] ref_w [0:51];
    task automatic expand_ref(input logic [191:0] k);
        for (int i = 0; i < 6; i++) ref_w[i] = k[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) ref_w[i] = next_word(i, ref_w[i-1], ref_w[i-6]);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [5:0]  wa [0:127];
    logic [31:0] wd [0:127];
    int          wc [0:127];
    int          n_wr, busy_n, rk_n, rk_bad;
    int          done_cyc [$];

    // Cycle c is the interval after the c-th rising edge following the edge that samples start.
    task automatic run(input logic [191:0] k, input int ncyc, input int pulse_at, input int rst_at, input bit hold);
        n_wr = 0; busy_n = 0; rk_n = 0; rk_bad = 0;
        done_cyc.delete();
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            if (wr_en && n_wr < 128) begin
                wa[n_wr] = wr_addr; wd[n_wr] = wr_data; wc[n_wr] = c;
                n_wr++;
            end
            if (done) done_cyc.push_back(c);
            if (busy) busy_n++;
`ifdef KEYEXP_RK_NOTIFY_EN
            if (rk_valid) begin
                rk_n++;
                if (!(wr_en && wr_addr[1:0] == 2'b11 && rk_idx == wr_addr[5:2])) rk_bad++;
            end
`endif
            if (c == pulse_at) begin
                start  = 1'b1;
                key_in = ~k;
            end else if (c == pulse_at + 1) begin
                start = 1'b0;
            end
            if (c == rst_at) rst = 1'b1;
            if (c == rst_at + 1) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_wr_en", 32'(wr_en), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                rst = 1'b0;
                break;
            end
            if (hold && done_cyc.size() == 2) start = 1'b0;
        end
    endtask

    task automatic check_sched(input string tag, input int base, input int first_cyc);
        for (int j = 0; j < 52; j++) begin
            chk($sformatf("%s_addr%0d", tag, j), 32'(wa[base+j]), 32'(j));
            chk($sformatf("%s_data%0d", tag, j), wd[base+j], ref_w[j]);
            chk($sformatf("%s_cyc%0d", tag, j), 32'(wc[base+j]), 32'(first_cyc + j));
        end
    endtask

    task automatic check_single(input string tag);
        chk({tag, "_nwr"}, 32'(n_wr), 32'd52);
        chk({tag, "_ndone"}, 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) chk({tag, "_done_lat"}, 32'(done_cyc[0]), 32'd53);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd52);
        if (n_wr >= 52) check_sched(tag, 0, 1);
`ifdef KEYEXP_RK_NOTIFY_EN
        chk({tag, "_rk_count"}, 32'(rk_n), 32'd13);
        chk({tag, "_rk_bad"}, 32'(rk_bad), 32'd0);
`endif
    endtask

    function automatic logic [191:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [191:0] fips_key, k;

    initial begin
        fips_key = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        rst = 1'b1; start = 1'b0; key_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_wg_i", 32'(wg_i), 32'd0);
`ifdef KEYEXP_RK_NOTIFY_EN
        chk("reset_rk_valid", 32'(rk_valid), 32'd0);
        chk("reset_rk_idx", 32'(rk_idx), 32'd0);
`endif
        rst = 1'b0;

        // FIPS-197 A.2 vector.
        expand_ref(fips_key);
        run(fips_key, 60, -10, -10, 1'b0);
        check_single("fips");
        if (n_wr >= 52) begin
            chk("fips_w0", wd[0], 32'h8e73b0f7);
            chk("fips_w5", wd[5], 32'h522c6b7b);
            chk("fips_w6", wd[6], 32'hfe0c91f7);
            chk("fips_w48", wd[48], 32'he98ba06f);
            chk("fips_w51", wd[51], 32'h01002202);
        end

        // A second start with a different key while busy must be ignored.
        run(fips_key, 60, 20, -10, 1'b0);
        check_single("restart");

        // A reset mid-run aborts without done; a fresh run then completes normally.
        k = rand_key();
        run(k, 60, -10, 30, 1'b0);
        chk("abort_ndone", 32'(done_cyc.size()), 32'd0);
        repeat (2) @(negedge clk);
        k = rand_key();
        expand_ref(k);
        run(k, 60, -10, -10, 1'b0);
        check_single("after_rst");

        // All-zero key.
        expand_ref('0);
        run('0, 60, -10, -10, 1'b0);
        check_single("zero");
        if (n_wr >= 52) begin
            chk("zero_w6", wd[6], 32'h62636363);
            chk("zero_w7", wd[7], 32'h62636363);
            chk("zero_w12", wd[12], 32'h9b9898c9);
        end

        // Start held high: the second run begins right after done.
        k = rand_key();
        expand_ref(k);
        run(k, 115, -10, -10, 1'b1);
        start = 1'b0;
        chk("b2b_nwr", 32'(n_wr), 32'd104);
        chk("b2b_ndone", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) begin
            chk("b2b_done0", 32'(done_cyc[0]), 32'd53);
            chk("b2b_done1", 32'(done_cyc[1]), 32'd107);
        end
        if (n_wr >= 104) begin
            check_sched("b2b_first", 0, 1);
            check_sched("b2b_second", 52, 55);
        end

        // Random keys.
        for (int r = 0; r < 2; r++) begin
            k = rand_key();
            expand_ref(k);
            run(k, 60, -10, -10, 1'b0);
            check_single($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
